glb_xbus_arbiter: RTL

//  Round-robin arbiter and burst sequencer for the shared X-bus that broadcasts data into the global PE set.
//  Up to NUM_REQ requesters (GLB banks / external loader) each post a tagged burst.
//  The arbiter grants one requester at a time and muxes its valid/data/tag stream onto the bus.
//  It counts beats and releases the bus on the last beat, so PE columns see one contiguous tagged burst.

---
 rtl/glb_xbus_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/glb_xbus_arbiter.sv
// glb_xbus_arbiter: round-robin arbiter + burst sequencer for the shared X-bus into the global PE set.
// Latency: grant registered one cycle after req is seen in IDLE; beats pass combinationally from owner to bus.
// Backpressure: i_bus_ready feeds straight back to the owner's o_req_ready; a stalled beat holds the counter.
//
// Ports:
//   i_clk, i_rst (async, active-high), i_flush (sync abort of current burst)
//   i_req / i_req_tag / i_req_len   per-requester burst request, tag, beats-1 (sampled in IDLE only)
//   i_req_valid / i_req_data        per-requester beat stream; o_req_ready back to the owner only
//   o_gnt                           registered one-hot grant
//   o_bus_valid/data/tag/last       X-bus beat output, i_bus_ready from the PE side
//   o_busy                          high while a burst is in progress
//   o_timeout_err                   1-cycle pulse on stall abort
// Optional feature: define GLB_XBUS_ARB_TIMEOUT_EN to abort bursts that stall for TIMEOUT_CYC cycles.
module glb_xbus_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 4,
    parameter int TAG_WIDTH   = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    i_req_tag,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    i_req_len,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic [NUM_REQ-1:0]              o_gnt,
    output logic                            o_bus_valid,
    output logic [DATA_WIDTH-1:0]           o_bus_data,
    output logic [TAG_WIDTH-1:0]            o_bus_tag,
    output logic                            o_bus_last,
    input  logic                            i_bus_ready,
    output logic                            o_busy,
    output logic                            o_timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_owner, w_owner_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [TAG_WIDTH-1:0] r_tag, w_tag_nxt;
    logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;

    logic                 w_xfer;
    logic                 w_own_valid;
    logic                 w_beat;
    logic                 w_abort;
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [IDX_W-1:0]     w_idx;

    assign w_xfer      = (r_state == S_XFER);
    assign w_own_valid = i_req_valid[r_owner];

    // Round-robin search: first set request starting just after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Flush masks the owner's stream for the cycle so no beat can count.
    assign o_bus_valid = w_xfer & ~i_flush & w_own_valid;
    assign o_bus_data  = w_xfer ? i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_bus_tag   = w_xfer ? r_tag : '0;
    assign o_bus_last  = o_bus_valid & (r_cnt == r_len);
    assign o_busy      = w_xfer;
    assign o_gnt       = r_gnt;
    assign w_beat      = o_bus_valid & i_bus_ready;

    always_comb begin
        o_req_ready = '0;
        if (w_xfer && !i_flush && i_bus_ready) begin
            o_req_ready[r_owner] = 1'b1;
        end
    end

`ifdef GLB_XBUS_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] r_stall;

    // Abort on the TIMEOUT_CYC-th consecutive beat-less cycle; a beat this cycle resets the count instead.
    assign w_abort = w_xfer & ~i_flush & ~(w_own_valid & i_bus_ready) &
                     (r_stall == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall <= '0;
        end else if (!w_xfer || w_beat) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    assign o_timeout_err = w_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_tag_nxt   = r_tag;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        if (i_flush || w_abort) begin
            // Abort wins over a last beat; owner still counts as served for fairness.
            if (w_xfer) begin
                w_ptr_nxt = r_owner;
            end
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                w_owner_nxt = w_pick;
                w_tag_nxt   = i_req_tag[w_pick*TAG_WIDTH +: TAG_WIDTH];
                w_len_nxt   = i_req_len[w_pick*LEN_WIDTH +: LEN_WIDTH];
                w_cnt_nxt   = '0;
                w_gnt_nxt   = NUM_REQ'(1) << w_pick;
                w_state_nxt = S_XFER;
            end
        end else if (w_beat) begin
            if (r_cnt == r_len) begin
                w_ptr_nxt   = r_owner;
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_tag   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tag   <= w_tag_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

endmodule
